conv_window_feeder: RTL and testbench

- Upstream stage of the convolution operator. Turns a scalar sample stream into sliding windows of LEN samples and presents each window with the stored kernel vector over a valid/ready handshake.
- Kernel coefficients are loaded once per frame and held stable.
- Stride is configurable. Frames are delimited by s_last so windows never straddle frames.

---
 rtl/conv_window_feeder_pkg.sv | 16 +
 rtl/conv_window_feeder_if.sv | 35 +++
 rtl/conv_shift_window.sv | 28 ++
 rtl/conv_window_feeder.sv | 106 ++++++++++
 tb/tb_conv_window_feeder.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_window_feeder_pkg.sv
// Shared convolution definitions: sample width, window/kernel length, the
// window/kernel vector type, and the feeder's FSM state encoding.
package conv_window_feeder_pkg;

  localparam int unsigned WIDTH = 64;
  localparam int unsigned LEN   = 4;

  // Element [0] is the oldest sample, [LEN-1] the newest.
  typedef logic [LEN-1:0][WIDTH-1:0] data_vector;

  typedef enum logic {
    StFill,
    StEmit
  } feeder_state_e;

endpackage

// File: rtl/conv_window_feeder_if.sv
// Handshake bundle of the window feeder.
//   kernel_in/kernel_load/kernel_ready  : kernel coefficient load
//   s_data/s_valid/s_ready/s_last       : scalar sample stream
//   data_out/kernel_out/out_valid/out_ready : window + kernel output
// master = environment side, slave = feeder side.
interface conv_window_feeder_if
  import conv_window_feeder_pkg::*;
#(
  parameter int unsigned WIDTH = conv_window_feeder_pkg::WIDTH,
  parameter int unsigned LEN   = conv_window_feeder_pkg::LEN
);

  logic [LEN-1:0][WIDTH-1:0] kernel_in;
  logic                      kernel_load;
  logic                      kernel_ready;
  logic [WIDTH-1:0]          s_data;
  logic                      s_valid;
  logic                      s_ready;
  logic                      s_last;
  logic [LEN-1:0][WIDTH-1:0] data_out;
  logic [LEN-1:0][WIDTH-1:0] kernel_out;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output kernel_in, kernel_load, s_data, s_valid, s_last, out_ready,
    input  kernel_ready, s_ready, data_out, kernel_out, out_valid
  );

  modport slave (
    input  kernel_in, kernel_load, s_data, s_valid, s_last, out_ready,
    output kernel_ready, s_ready, data_out, kernel_out, out_valid
  );

endinterface

// File: rtl/conv_shift_window.sv
// LEN-deep shift register holding the most recent samples.
//   clk, rst  : clock, asynchronous active-high reset
//   shift_en  : shift s_data in at the newest end
//   s_data    : incoming sample
//   window    : [0]=oldest .. [LEN-1]=newest
module conv_shift_window #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned LEN   = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      shift_en,
  input  logic [WIDTH-1:0]          s_data,
  output logic [LEN-1:0][WIDTH-1:0] window
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      window <= '0;
    end else if (shift_en) begin
      for (int i = 0; i < int'(LEN) - 1; i++) begin
        window[i] <= window[i+1];
      end
      window[LEN-1] <= s_data;
    end
  end

endmodule

// File: rtl/conv_window_feeder.sv
// Turns a sample stream into sliding windows of LEN samples and presents
// each window together with the stored kernel over a valid/ready handshake.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : conv_window_feeder_if slave (kernel load, sample stream,
//              window/kernel output)
module conv_window_feeder
  import conv_window_feeder_pkg::*;
#(
  parameter int unsigned WIDTH  = conv_window_feeder_pkg::WIDTH,
  parameter int unsigned LEN    = conv_window_feeder_pkg::LEN,
  parameter int unsigned STRIDE = 1
) (
  input logic                 clk,
  input logic                 rst,
  conv_window_feeder_if.slave bus
);

  localparam int unsigned CntW = $clog2(LEN + 1);
  localparam logic [CntW-1:0] LenC    = CntW'(LEN);
  localparam logic [CntW-1:0] StrideC = CntW'(STRIDE);

  feeder_state_e             state_q, state_d;
  logic [CntW-1:0]           fill_q, fill_d;
  // Set once the frame's first window has been emitted; reset value 0 means
  // "next window is the first of a frame".
  logic                      mid_q, mid_d;
  // Emitted window contains the frame's s_last.
  logic                      last_q, last_d;
  logic [LEN-1:0][WIDTH-1:0] kernel_q;

  logic            accept;
  logic [CntW-1:0] fill_inc;
  logic [CntW-1:0] target;

  assign bus.s_ready      = (state_q == StFill);
  assign bus.out_valid    = (state_q == StEmit);
  assign bus.kernel_ready = (state_q == StFill) && (fill_q == '0) && !mid_q;
  assign bus.kernel_out   = kernel_q;

  assign accept   = bus.s_valid && bus.s_ready;
  assign fill_inc = fill_q + 1'b1;
  assign target   = mid_q ? StrideC : LenC;

  conv_shift_window #(
    .WIDTH (WIDTH),
    .LEN   (LEN)
  ) u_window (
    .clk      (clk),
    .rst      (rst),
    .shift_en (accept),
    .s_data   (bus.s_data),
    .window   (bus.data_out)
  );

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    mid_d   = mid_q;
    last_d  = last_q;
    unique case (state_q)
      StFill: begin
        if (accept) begin
          if (fill_inc == target) begin
            state_d = StEmit;
            fill_d  = fill_inc;
            last_d  = bus.s_last;
          end else if (bus.s_last) begin
            // Partial frame: drop it and wait for a full first window.
            fill_d = '0;
            mid_d  = 1'b0;
          end else begin
            fill_d = fill_inc;
          end
        end
      end
      StEmit: begin
        if (bus.out_ready) begin
          state_d = StFill;
          fill_d  = '0;
          mid_d   = !last_q;
          last_d  = 1'b0;
        end
      end
      default: state_d = StFill;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFill;
      fill_q   <= '0;
      mid_q    <= 1'b0;
      last_q   <= 1'b0;
      kernel_q <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      mid_q   <= mid_d;
      last_q  <= last_d;
      if (bus.kernel_load && bus.kernel_ready) begin
        kernel_q <= bus.kernel_in;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: one instance with STRIDE=1 and one with
// STRIDE=2, each tracked every cycle by a frame-level reference model.
module tb_conv_window_feeder;
  import conv_window_feeder_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv_window_feeder_if if0 ();
  conv_window_feeder_if if1 ();

  conv_window_feeder #(.STRIDE(1)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  conv_window_feeder #(.STRIDE(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // Stimulus, indexed by instance.
  logic [1:0]       sv, sl, kl, ordy;
  logic [WIDTH-1:0] sd  [2];
  data_vector       kin [2];

  assign if0.s_valid = sv[0];   assign if1.s_valid = sv[1];
  assign if0.s_last = sl[0];    assign if1.s_last = sl[1];
  assign if0.s_data = sd[0];    assign if1.s_data = sd[1];
  assign if0.kernel_load = kl[0]; assign if1.kernel_load = kl[1];
  assign if0.kernel_in = kin[0];  assign if1.kernel_in = kin[1];
  assign if0.out_ready = ordy[0]; assign if1.out_ready = ordy[1];

  logic [1:0] ov, srdy, kr;
  data_vector dout [2];
  data_vector kout [2];
  assign ov   = {if1.out_valid, if0.out_valid};
  assign srdy = {if1.s_ready, if0.s_ready};
  assign kr   = {if1.kernel_ready, if0.kernel_ready};
  assign dout[0] = if0.data_out;   assign dout[1] = if1.data_out;
  assign kout[0] = if0.kernel_out; assign kout[1] = if1.kernel_out;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: samples seen in the current frame, the last LEN of
  // them, the window waiting for a transfer, and the expected kernel.
  int         strd [2] = '{1, 2};
  int         n    [2];
  bit         pend [2];
  bit         acc  [2];
  data_vector hist [2];
  data_vector pwin [2];
  data_vector kexp [2];

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic data_vector mk(input int a, input int b, input int c, input int e);
    data_vector v;
    v[0] = WIDTH'(a); v[1] = WIDTH'(b); v[2] = WIDTH'(c); v[3] = WIDTH'(e);
    return v;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      n[d] = 0; pend[d] = 0; acc[d] = 0;
      hist[d] = '0; pwin[d] = '0; kexp[d] = '0;
    end
  endtask

  // Called just after a falling edge with inputs already applied: checks the
  // DUTs against the model, advances the model over the next rising edge.
  task automatic tick();
    bit krm;
    #1;
    for (int d = 0; d < 2; d++) begin
      krm = !pend[d] && (n[d] == 0);
      chk($sformatf("d%0d_out_valid", d), 256'(ov[d]), 256'(pend[d]));
      chk($sformatf("d%0d_s_ready", d), 256'(srdy[d]), 256'(!pend[d]));
      chk($sformatf("d%0d_kernel_ready", d), 256'(kr[d]), 256'(krm));
      chk($sformatf("d%0d_kernel_out", d), kout[d], kexp[d]);
      chk($sformatf("d%0d_data_out", d), dout[d], pend[d] ? pwin[d] : hist[d]);
      if (!rst) begin
        if (kl[d] && krm) kexp[d] = kin[d];
        acc[d] = 0;
        if (pend[d]) begin
          if (ordy[d]) pend[d] = 0;
        end else if (sv[d]) begin
          acc[d] = 1;
          for (int i = 0; i < int'(LEN) - 1; i++) hist[d][i] = hist[d][i+1];
          hist[d][LEN-1] = sd[d];
          n[d]++;
          if (n[d] >= int'(LEN) && (n[d] - int'(LEN)) % strd[d] == 0) begin
            pend[d] = 1;
            pwin[d] = hist[d];
          end
          if (sl[d]) n[d] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic send(input int d, input int v, input logic last);
    bit got = 0;
    sv[d] = 1'b1; sd[d] = WIDTH'(v); sl[d] = last;
    for (int k = 0; k < 20 && !got; k++) begin
      tick();
      got = acc[d];
    end
    sv[d] = 1'b0; sl[d] = 1'b0;
    chk($sformatf("d%0d_send_accepted", d), 256'(got), 256'(1));
  endtask

  initial begin
    sv = '0; sl = '0; kl = '0; ordy = '0;
    for (int d = 0; d < 2; d++) begin sd[d] = '0; kin[d] = '0; end
    model_reset();

    // Reset state.
    @(negedge clk);
    tick();
    rst = 1'b0;
    tick();
    chk("reset_s_ready", 256'(srdy), 256'(2'b11));
    chk("reset_kernel_ready", 256'(kr), 256'(2'b11));

    // Kernel load and first window.
    kl[0] = 1'b1; kin[0] = mk(1, 2, 3, 4);
    tick();
    kl[0] = 1'b0;
    send(0, 10, 0); send(0, 20, 0); send(0, 30, 0);
    chk("pre_window_valid", 256'(ov[0]), 256'(0));
    send(0, 40, 0);
    chk("first_valid", 256'(ov[0]), 256'(1));
    chk("first_window", dout[0], mk(10, 20, 30, 40));
    chk("first_kernel", kout[0], mk(1, 2, 3, 4));

    // Backpressure.
    repeat (5) tick();
    chk("bp_valid", 256'(ov[0]), 256'(1));
    chk("bp_s_ready", 256'(srdy[0]), 256'(0));
    chk("bp_window", dout[0], mk(10, 20, 30, 40));
    ordy[0] = 1'b1;
    tick();
    chk("bp_released_valid", 256'(ov[0]), 256'(0));
    chk("bp_released_s_ready", 256'(srdy[0]), 256'(1));
    send(0, 50, 0);
    chk("second_window", dout[0], mk(20, 30, 40, 50));

    // s_last completing a window, then a fresh frame.
    send(0, 60, 1);
    chk("last_window", dout[0], mk(30, 40, 50, 60));
    chk("last_kernel_ready_busy", 256'(kr[0]), 256'(0));
    tick();
    chk("after_last_kernel_ready", 256'(kr[0]), 256'(1));

    // Partial frame is dropped.
    send(0, 10, 0); send(0, 20, 0); send(0, 30, 1);
    chk("partial_no_valid", 256'(ov[0]), 256'(0));
    chk("partial_kernel_ready", 256'(kr[0]), 256'(1));
    send(0, 5, 0); send(0, 6, 0);
    kl[0] = 1'b1; kin[0] = mk(9, 9, 9, 9);
    tick();
    kl[0] = 1'b0;
    chk("ignored_kernel", kout[0], mk(1, 2, 3, 4));
    send(0, 7, 0);
    chk("restart_no_valid", 256'(ov[0]), 256'(0));
    send(0, 8, 0);
    chk("restart_valid", 256'(ov[0]), 256'(1));
    chk("restart_window", dout[0], mk(5, 6, 7, 8));
    tick();

    // STRIDE=2 instance.
    ordy[1] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(1, k, 0);
      chk($sformatf("s2_valid_%0d", k), 256'(ov[1]), 256'(k == 4 || k == 6 || k == 8));
      if (k == 4 || k == 6 || k == 8)
        chk($sformatf("s2_window_%0d", k), dout[1], mk(k - 3, k - 2, k - 1, k));
    end
    tick();

    // Randomized traffic on both instances.
    for (int c = 0; c < 1500; c++) begin
      for (int d = 0; d < 2; d++) begin
        sv[d]   = ($urandom_range(0, 3) != 0);
        sd[d]   = {$urandom, $urandom};
        sl[d]   = ($urandom_range(0, 7) == 0);
        kl[d]   = ($urandom_range(0, 5) == 0);
        for (int i = 0; i < int'(LEN); i++) kin[d][i] = {$urandom, $urandom};
        ordy[d] = $urandom_range(0, 1);
      end
      tick();
    end
    sv = '0; sl = '0; kl = '0;

    // Asynchronous reset while a window is pending.
    ordy[0] = 1'b0; sv[0] = 1'b1; sd[0] = WIDTH'(77);
    for (int k = 0; k < 40 && !pend[0]; k++) tick();
    sv[0] = 1'b0;
    chk("reach_emit", 256'(ov[0]), 256'(1));
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", 256'(ov[0]), 256'(0));
    chk("async_rst_data", dout[0], 256'(0));
    chk("async_rst_kernel", kout[0], 256'(0));
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    tick();
    chk("post_rst_s_ready", 256'(srdy[0]), 256'(1));
    chk("post_rst_kernel_ready", 256'(kr[0]), 256'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
